// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop FSM, tick prescaler, two-digit BCD counter and
// seven-segment digit multiplexer for a two-digit stopwatch.
// Ports: clk (system clock), rst (async active-low reset), start/stop
// (level inputs, rising-edge acting), running (high in RUN), digit_ones/
// digit_tens (displayed BCD digits), disp_val (digit routed to the shared
// decoder), seg_en1/seg_en2 (one-hot digit enables), wrap (99->00 pulse).
// Optional LAP_EN macro adds input lap, which freezes the displayed digits
// while the internal count keeps running.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 12500000,
  parameter int MUX_DIV  = 125000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
`ifdef LAP_EN
  input  logic       lap,
`endif
  output logic       running,
  output logic [3:0] digit_ones,
  output logic [3:0] digit_tens,
  output logic [3:0] disp_val,
  output logic       seg_en1,
  output logic       seg_en2,
  output logic       wrap
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;
  localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MUX_END  = MW'(MUX_DIV - 1);

  logic [1:0]    state, state_n;
  logic          start_q, stop_q, start_edge, stop_edge;
  logic [TW-1:0] presc, presc_n;
  logic [MW-1:0] mux_cnt, mux_n;
  logic [3:0]    ones, tens, ones_n, tens_n, d_ones_n, d_tens_n;
  logic          tick, clr, mux_end, sel_n, wrap_n, frozen_n;
`ifdef LAP_EN
  logic          lap_q, frozen;
`endif

  always_comb begin
    start_edge = start & ~start_q;
    stop_edge  = stop & ~stop_q;
    // stop has priority over start in every state
    state_n    = (state == 2'd3) ? IDLE :
                 stop_edge ? ((state == RUN) ? PAUSE : IDLE) :
                 start_edge ? RUN : state;
    tick       = (state == RUN) && (presc == TICK_END);
    // PAUSE -> IDLE clears count; IDLE keeps prescaler at zero
    clr        = (state == PAUSE) && (state_n == IDLE);
    presc_n    = (clr || state == IDLE || tick) ? '0 :
                 (state == RUN) ? presc + TW'(1) : presc;
    ones_n     = clr ? 4'd0 : !tick ? ones : (ones == 4'd9) ? 4'd0 : ones + 4'd1;
    tens_n     = clr ? 4'd0 : !(tick && ones == 4'd9) ? tens :
                 (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    wrap_n     = tick && ones == 4'd9 && tens == 4'd9;
    mux_end    = mux_cnt == MUX_END;
    mux_n      = mux_end ? '0 : mux_cnt + MW'(1);
    sel_n      = seg_en2 ^ mux_end;
`ifdef LAP_EN
    // lap toggles the freeze only while staying in RUN; leaving RUN releases it
    frozen_n   = (state_n == RUN) && (frozen ^ (lap & ~lap_q & (state == RUN)));
`else
    frozen_n   = 1'b0;
`endif
    d_ones_n   = frozen_n ? digit_ones : ones_n;
    d_tens_n   = frozen_n ? digit_tens : tens_n;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      presc      <= '0;
      mux_cnt    <= '0;
      ones       <= 4'd0;
      tens       <= 4'd0;
      running    <= 1'b0;
      digit_ones <= 4'd0;
      digit_tens <= 4'd0;
      disp_val   <= 4'd0;
      seg_en1    <= 1'b1;
      seg_en2    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_n;
      start_q    <= start;
      stop_q     <= stop;
      presc      <= presc_n;
      mux_cnt    <= mux_n;
      ones       <= ones_n;
      tens       <= tens_n;
      running    <= state_n == RUN;
      digit_ones <= d_ones_n;
      digit_tens <= d_tens_n;
      // built from next-cycle values so it always matches the enables
      disp_val   <= sel_n ? d_tens_n : d_ones_n;
      seg_en1    <= ~sel_n;
      seg_en2    <= sel_n;
      wrap       <= wrap_n;
    end

`ifdef LAP_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lap_q  <= 1'b0;
      frozen <= 1'b0;
    end else begin
      lap_q  <= lap;
      frozen <= frozen_n;
    end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
`ifdef LAP_EN
  logic lap = 1'b0;
`endif
  logic running, seg_en1, seg_en2, wrap;
  logic [3:0] digit_ones, digit_tens, disp_val;
  int n_tests = 0, n_fail = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .MUX_DIV(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef LAP_EN
    .lap(lap),
`endif
    .running(running), .digit_ones(digit_ones), .digit_tens(digit_tens),
    .disp_val(disp_val), .seg_en1(seg_en1), .seg_en2(seg_en2), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int t, input int o);
    chk({tag, "_tens"}, digit_tens, t);
    chk({tag, "_ones"}, digit_ones, o);
    chk({tag, "_onehot"}, {seg_en1, seg_en2}, seg_en1 ? 2'b10 : 2'b01);
    chk({tag, "_disp"}, disp_val, seg_en1 ? o : t);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_ones"}, digit_ones, 0);
    chk({tag, "_tens"}, digit_tens, 0);
    chk({tag, "_disp"}, disp_val, 0);
    chk({tag, "_en1"}, seg_en1, 1);
    chk({tag, "_en2"}, seg_en2, 0);
    chk({tag, "_wrap"}, wrap, 0);
  endtask

  initial begin
    #23;
    chk_rst("rst");
    @(negedge clk) rst = 1'b1;
    step(1);
    chk("mux1_en1", seg_en1, 1);
    step(2);
    chk("mux3_en2", seg_en2, 1);
    chk("mux3_en1", seg_en1, 0);
    step(2);
    chk("mux5_en2", seg_en2, 1);
    step(1);
    chk("mux6_en1", seg_en1, 1);
    chk("mux6_en2", seg_en2, 0);
    // start; E0 is the edge entering RUN
    start = 1'b1;
    step(1);
    chk("start_run", running, 1);
    step(3);
    chk_cnt("e3", 0, 0);
    step(1);
    chk_cnt("e4", 0, 1);
    step(35);
    chk_cnt("e39", 0, 9);
    step(1);
    chk_cnt("e40", 1, 0);
    start = 1'b0;
    // wrap
    step(355);
    chk_cnt("e395", 9, 8);
    step(1);
    chk_cnt("e396", 9, 9);
    chk("e396_wrap", wrap, 0);
    step(3);
    chk("e399_wrap", wrap, 0);
    step(1);
    chk_cnt("e400", 0, 0);
    chk("e400_wrap", wrap, 1);
    chk("e400_run", running, 1);
    step(1);
    chk("e401_wrap", wrap, 0);
    chk("e401_run", running, 1);
    // pause at 07 with prescaler one step in
    step(27);
    chk_cnt("e428", 0, 7);
    stop = 1'b1;
    step(1);
    chk("pause_run", running, 0);
    stop = 1'b0;
    step(50);
    chk_cnt("pause_hold", 0, 7);
    chk("pause_hold_run", running, 0);
    start = 1'b1;
    step(1);
    chk("resume_run", running, 1);
    start = 1'b0;
    step(2);
    chk_cnt("resume2", 0, 7);
    step(1);
    chk_cnt("resume3", 0, 8);
    stop = 1'b1;
    step(1);
    chk("pause2_run", running, 0);
    stop = 1'b0;
    step(1);
    stop = 1'b1;
    step(1);
    chk_cnt("clear", 0, 0);
    chk("clear_run", running, 0);
    stop = 1'b0;
    step(1);
    // simultaneous in IDLE, then held start level
    start = 1'b1; stop = 1'b1;
    step(1);
    chk("both_idle_run", running, 0);
    step(5);
    chk("both_idle_held", running, 0);
    start = 1'b0; stop = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("held_start_run", running, 1);
    stop = 1'b1;
    step(1);
    chk("held_pause", running, 0);
    stop = 1'b0;
    step(10);
    chk("held_no_resume", running, 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("resume_b", running, 1);
    start = 1'b0;
    step(9);
    chk_cnt("pre_both", 0, 2);
    start = 1'b1; stop = 1'b1;
    step(1);
    chk("both_run_pause", running, 0);
    chk_cnt("both_run_keep", 0, 2);
    start = 1'b0; stop = 1'b0;
    step(1);
    stop = 1'b1;
    step(1);
    chk_cnt("clear2", 0, 0);
    stop = 1'b0;
    step(1);
    // async reset at count 35
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(140);
    chk_cnt("c35", 3, 5);
    chk("c35_run", running, 1);
    #2 rst = 1'b0;
    #1 chk_rst("arst");
    @(negedge clk) rst = 1'b1;
    step(5);
    chk("post_rst_run", running, 0);
    chk_cnt("post_rst", 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
